// File: rtl/string_dl_ctrl.sv
// Delay-line sequencer for the waveguide string: per sample, read the tap at wptr-dly,
// then write the new sample at wptr; also bulk-zeroes the RAM on request.
module string_dl_ctrl #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 18
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [ADDR_W-1:0] dly_i,
    input  logic              in_stb_i,
    input  logic [DATA_W-1:0] in_sample_i,
    input  logic              clr_i,
    output logic              busy_o,
    output logic              out_stb_o,
    output logic [DATA_W-1:0] out_sample_o,
    output logic              ovr_o,
    output logic              ram_wrt_o,
    output logic [ADDR_W-1:0] ram_a_o,
    output logic [DATA_W-1:0] ram_i_o,
    input  logic [DATA_W-1:0] ram_o_i
);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StClr} state_e;

    localparam logic [ADDR_W-1:0] LastAddr = '1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] ram_a_q, ram_a_d;
    logic [DATA_W-1:0] smp_q, smp_d;
    logic [DATA_W-1:0] ram_wd_q, ram_wd_d;
    logic [DATA_W-1:0] out_sample_q, out_sample_d;
    logic              ram_wrt_q, ram_wrt_d;
    logic              out_stb_q, out_stb_d;
    logic              ovr_q, ovr_d;
    logic              busy_q, busy_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            wptr_q       <= '0;
            ram_a_q      <= '0;
            smp_q        <= '0;
            ram_wd_q     <= '0;
            out_sample_q <= '0;
            ram_wrt_q    <= 1'b0;
            out_stb_q    <= 1'b0;
            ovr_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            ram_a_q      <= ram_a_d;
            smp_q        <= smp_d;
            ram_wd_q     <= ram_wd_d;
            out_sample_q <= out_sample_d;
            ram_wrt_q    <= ram_wrt_d;
            out_stb_q    <= out_stb_d;
            ovr_q        <= ovr_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (clr_i) begin
                    state_d = StClr;
                end else if (in_stb_i) begin
                    state_d = StRd;
                end
            end
            StRd:    state_d = StWr;
            StWr:    state_d = StIdle;
            StClr: begin
                if (ram_a_q == LastAddr) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs; busy tracks the registered state one-for-one.
    always_comb begin
        wptr_d       = wptr_q;
        ram_a_d      = ram_a_q;
        smp_d        = smp_q;
        ram_wd_d     = ram_wd_q;
        out_sample_d = out_sample_q;
        ram_wrt_d    = 1'b0;
        out_stb_d    = 1'b0;
        ovr_d        = ovr_q;
        busy_d       = (state_d != StIdle);
        unique case (state_q)
            StIdle: begin
                if (clr_i) begin
                    ram_a_d   = '0;
                    ram_wd_d  = '0;
                    ram_wrt_d = 1'b1;
                    if (in_stb_i) begin
                        ovr_d = 1'b1;
                    end
                end else if (in_stb_i) begin
                    smp_d   = in_sample_i;
                    ram_a_d = wptr_q - dly_i;
                end
            end
            StRd: begin
                ram_a_d   = wptr_q;
                ram_wd_d  = smp_q;
                ram_wrt_d = 1'b1;
                if (in_stb_i) begin
                    ovr_d = 1'b1;
                end
            end
            StWr: begin
                // ram_o_i still holds the tap read; the write lands on this same edge.
                out_sample_d = ram_o_i;
                out_stb_d    = 1'b1;
                wptr_d       = wptr_q + 1'b1;
                if (in_stb_i) begin
                    ovr_d = 1'b1;
                end
            end
            StClr: begin
                if (ram_a_q == LastAddr) begin
                    wptr_d = '0;
                end else begin
                    ram_a_d   = ram_a_q + 1'b1;
                    ram_wrt_d = 1'b1;
                end
                if (in_stb_i) begin
                    ovr_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign busy_o       = busy_q;
    assign out_stb_o    = out_stb_q;
    assign out_sample_o = out_sample_q;
    assign ovr_o        = ovr_q;
    assign ram_wrt_o    = ram_wrt_q;
    assign ram_a_o      = ram_a_q;
    assign ram_i_o      = ram_wd_q;

endmodule

// File: tb/tb_string_dl_ctrl.sv
// Bench for string_dl_ctrl: behavioural 2048x18 write-first RAM, table-driven accesses,
// and hand-written sequences for clear, wrap, overrun and reset corner cases.
module tb_string_dl_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] dly;
    logic        in_stb;
    logic [17:0] in_sample;
    logic        clr;
    logic        busy;
    logic        out_stb;
    logic [17:0] out_sample;
    logic        ovr;
    logic        ram_wrt;
    logic [10:0] ram_a;
    logic [17:0] ram_wd;
    logic [17:0] ram_rd;

    logic        scramble;
    logic [17:0] mem [2048];

    int n_vec = 0;
    int n_bad = 0;
    logic [10:0] mw;

    string_dl_ctrl #(.ADDR_W(11), .DATA_W(18)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .dly_i        (dly),
        .in_stb_i     (in_stb),
        .in_sample_i  (in_sample),
        .clr_i        (clr),
        .busy_o       (busy),
        .out_stb_o    (out_stb),
        .out_sample_o (out_sample),
        .ovr_o        (ovr),
        .ram_wrt_o    (ram_wrt),
        .ram_a_o      (ram_a),
        .ram_i_o      (ram_wd),
        .ram_o_i      (ram_rd)
    );

    always #5 clk = ~clk;

    // Write-first synchronous RAM; pre-filled with non-zero junk so the clear is observable.
    always @(posedge clk) begin
        if (scramble) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 18'(i) ^ 18'h2A5A5;
        end else if (ram_wrt) begin
            mem[ram_a] <= ram_wd;
            ram_rd     <= ram_wd;
        end else begin
            ram_rd <= mem[ram_a];
        end
    end

    typedef struct {
        logic [10:0] d;
        logic [17:0] s;
        logic [17:0] e;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called just after a negedge; returns at the negedge where out_stb is seen (or timeout).
    task automatic access(input logic [10:0] d, input logic [17:0] s, output logic [17:0] q,
                          output int lat, output logic [10:0] rd_a, output logic [10:0] wr_a);
        dly = d; in_sample = s; in_stb = 1'b1;
        @(negedge clk);
        in_stb = 1'b0; dly = ~d; in_sample = ~s;
        rd_a = ram_a;
        wr_a = '0;
        lat = 1;
        while (!out_stb && lat < 8) begin
            @(negedge clk);
            lat++;
            if (lat == 2) wr_a = ram_a;
        end
        q = out_sample;
    endtask

    task automatic do_clear(input logic with_stb);
        int errs;
        clr = 1'b1; in_stb = with_stb;
        @(negedge clk);
        clr = 1'b0; in_stb = 1'b0;
        if (with_stb) check("clr_stb_ovr", 32'(ovr), 1);
        errs = 0;
        for (int i = 0; i < 2048; i++) begin
            if (!(busy && ram_wrt && !out_stb && ram_a == 11'(i) && ram_wd == 18'h0)) errs++;
            if (i < 2047) @(negedge clk);
        end
        check("clr_seq", 32'(errs), 0);
        @(negedge clk);
        check("clr_done_busy", 32'(busy), 0);
        check("clr_done_wrt", 32'(ram_wrt), 0);
        errs = 0;
        for (int i = 0; i < 2048; i++) if (mem[i] != 18'h0) errs++;
        check("clr_mem", 32'(errs), 0);
        mw = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [17:0] q;
        logic [10:0] ra, wa;
        int lat, errs;

        tbl[0]  = '{11'd3,  18'd1,       18'd0};
        tbl[1]  = '{11'd3,  18'd2,       18'd0};
        tbl[2]  = '{11'd3,  18'd3,       18'd0};
        tbl[3]  = '{11'd3,  18'd4,       18'd1};
        tbl[4]  = '{11'd3,  18'd5,       18'd2};
        tbl[5]  = '{11'd3,  18'd6,       18'd3};
        tbl[6]  = '{11'd1,  18'd7,       18'd6};
        tbl[7]  = '{11'd6,  18'd8,       18'd2};
        tbl[8]  = '{11'd2,  18'd9,       18'd7};
        tbl[9]  = '{11'd1,  18'h3FFFF,   18'd9};
        tbl[10] = '{11'd1,  18'd5,       18'h3FFFF};
        tbl[11] = '{11'd12, 18'h20,      18'd0};

        reset = 1'b1; scramble = 1'b1;
        dly = '0; in_stb = 1'b0; in_sample = '0; clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_out_stb", 32'(out_stb), 0);
        check("rst_out_sample", 32'(out_sample), 0);
        check("rst_ovr", 32'(ovr), 0);
        check("rst_ram_wrt", 32'(ram_wrt), 0);
        check("rst_ram_a", 32'(ram_a), 0);
        check("rst_ram_i", 32'(ram_wd), 0);
        reset = 1'b0; scramble = 1'b0;
        @(negedge clk);

        do_clear(1'b0);

        // Back-to-back accesses at full throughput.
        for (int v = 0; v < 12; v++) begin
            access(tbl[v].d, tbl[v].s, q, lat, ra, wa);
            check($sformatf("vec%0d_rd_a", v), 32'(ra), 32'(11'(mw - tbl[v].d)));
            check($sformatf("vec%0d_wr_a", v), 32'(wa), 32'(mw));
            check($sformatf("vec%0d_lat", v), 32'(lat), 3);
            check($sformatf("vec%0d_data", v), 32'(q), 32'(tbl[v].e));
            mw = mw + 11'd1;
        end

        // dly=0 is a full 2048-sample delay; write address wraps 2047 -> 0.
        do_clear(1'b0);
        errs = 0;
        for (int k = 1; k <= 2049; k++) begin
            access(11'd0, 18'(k), q, lat, ra, wa);
            if (lat != 3 || ra != mw || wa != mw) errs++;
            if (k <= 2048 && q != 18'h0) errs++;
            if (k == 2048) check("wrap_wa_2047", 32'(wa), 2047);
            if (k == 2049) begin
                check("wrap_wa_0", 32'(wa), 0);
                check("full_delay_data", 32'(q), 1);
            end
            mw = mw + 11'd1;
        end
        check("full_delay_seq", 32'(errs), 0);

        // Strobe in the cycle after an accepted one is dropped.
        check("ovr_before", 32'(ovr), 0);
        dly = 11'd1; in_sample = 18'h155; in_stb = 1'b1;
        @(negedge clk);
        in_sample = 18'h2AA; dly = 11'd0;
        @(negedge clk);
        in_stb = 1'b0;
        @(negedge clk);
        check("ovr_out_stb", 32'(out_stb), 1);
        check("ovr_out_data", 32'(out_sample), 32'h801);
        check("ovr_set", 32'(ovr), 1);
        mw = mw + 11'd1;
        access(11'd1, 18'h33, q, lat, ra, wa);
        check("ovr_next_wa", 32'(wa), 2);
        check("ovr_next_data", 32'(q), 32'h155);
        mw = mw + 11'd1;

        // Reset during WR aborts the access and rewinds wptr.
        dly = 11'd1; in_sample = 18'h77; in_stb = 1'b1;
        @(negedge clk);
        in_stb = 1'b0;
        @(negedge clk);
        check("wr_state_wrt", 32'(ram_wrt), 1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_wrt", 32'(ram_wrt), 0);
        check("abort_out_stb", 32'(out_stb), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_ovr", 32'(ovr), 0);
        reset = 1'b0;
        @(negedge clk);
        check("abort_no_stb", 32'(out_stb), 0);
        mw = '0;
        access(11'd2, 18'h11, q, lat, ra, wa);
        check("post_rst_rd_a", 32'(ra), 2046);
        check("post_rst_wr_a", 32'(wa), 0);
        check("post_rst_data", 32'(q), 32'h7FF);

        // clr wins over a simultaneous in_stb; clr while busy is ignored.
        @(negedge clk);
        do_clear(1'b1);
        dly = 11'd1; in_sample = 18'h42; in_stb = 1'b1;
        @(negedge clk);
        in_stb = 1'b0; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        check("busy_clr_out_stb", 32'(out_stb), 1);
        check("busy_clr_data", 32'(out_sample), 0);
        @(negedge clk);
        check("busy_clr_idle", 32'(busy), 0);
        check("busy_clr_wrt", 32'(ram_wrt), 0);
        check("busy_clr_mem", 32'(mem[0]), 32'h42);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
